// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OWN0, OWN1, ABORT)
//   M0 / M1     : master index values, as stored in the last-grant register
package wb_arb_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      ABORT = 2'd3
   } arb_state_e;
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: bus-stall watchdog that aborts a transfer whose STB waits too long for ACK/ERR.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   active_i       : a master currently owns the slave
//   stb_i          : slave strobe as presented to the slave
//   resp_i         : slave ACK or ERR this cycle
//   clear_i        : arbiter state changes at the next edge
//   abort_o        : combinational, the current cycle is the last tolerated stall cycle
//   timeout_o      : registered one-cycle pulse following abort_o
module wb_arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic active_i,
   input  logic stb_i,
   input  logic resp_i,
   input  logic clear_i,
   output logic abort_o,
   output logic timeout_o
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q;
   logic          stall;
   // A response in the limit cycle is not a stall, so an ack always beats the abort.
   assign stall     = active_i & stb_i & ~resp_i;
   assign abort_o   = (TIMEOUT > 0) && stall && (cnt_q == LIMIT);
   // Saturating count of consecutive stalled cycles; never wraps back to zero.
   assign cnt_d     = (TIMEOUT == 0 || !stall || clear_i) ? '0 : (&cnt_q) ? cnt_q : cnt_q + CW'(1);
   assign timeout_o = timeout_q;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= abort_o;
      end
   end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master, one-slave Wishbone classic round-robin arbiter with stall watchdog.
//   clk_i, rst_n_i             : clock, asynchronous active-low reset
//   m0_* / m1_*                : master ports (cyc/stb/we/sel/adr/dat in; dat/ack/err out)
//   s_*                        : slave port (cyc/stb/we/sel/adr/dat out; dat/ack/err in)
//   timeout_o                  : one-cycle pulse when the watchdog aborts a transfer
// Ownership is held for a whole CYC; ties go to the master that was not granted last.
module wb_rr_arbiter import wb_arb_pkg::*; #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   output logic            timeout_o
);
   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       own0, own1, wd_abort, wd_timeout, owner_cyc;
   assign own0      = (state_q == OWN0);
   assign own1      = (state_q == OWN1);
   // In ABORT the last-grant register still names the master being aborted.
   assign owner_cyc = (last_grant_q == M0) ? m0_cyc_i : m1_cyc_i;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = (m0_cyc_i && (!m1_cyc_i || last_grant_q == M1)) ? OWN0 :
                          m1_cyc_i ? OWN1 : IDLE;
         OWN0:  state_d = wd_abort ? ABORT : m0_cyc_i ? OWN0 : m1_cyc_i ? OWN1 : IDLE;
         OWN1:  state_d = wd_abort ? ABORT : m1_cyc_i ? OWN1 : m0_cyc_i ? OWN0 : IDLE;
         ABORT: state_d = owner_cyc ? ABORT : IDLE;
      endcase
   end
   assign last_grant_d = (state_d == OWN0) ? M0 : (state_d == OWN1) ? M1 : last_grant_q;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         last_grant_q <= M1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end
   assign s_cyc_o  = own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0;
   assign s_stb_o  = own0 ? m0_stb_i : own1 ? m1_stb_i : 1'b0;
   assign s_we_o   = own0 ? m0_we_i  : own1 ? m1_we_i  : 1'b0;
   assign s_sel_o  = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
   assign s_adr_o  = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
   assign s_dat_o  = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = own0 & s_ack_i;
   assign m1_ack_o = own1 & s_ack_i;
   // The watchdog pulse is only ever high in the first ABORT cycle.
   assign m0_err_o = (own0 & s_err_i) | (wd_timeout & (last_grant_q == M0));
   assign m1_err_o = (own1 & s_err_i) | (wd_timeout & (last_grant_q == M1));
   assign timeout_o = wd_timeout;
   wb_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .active_i  (own0 | own1),
      .stb_i     (s_stb_o),
      .resp_i    (s_ack_i | s_err_i),
      .clear_i   (state_d != state_q),
      .abort_o   (wd_abort),
      .timeout_o (wd_timeout)
   );
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter with an 8-cycle watchdog.
module tb_wb_rr_arbiter;
   localparam logic [31:0] A0 = 32'h0000_0A00;
   localparam logic [31:0] A1 = 32'h0000_0B00;
   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
   logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, timeout_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   int          total = 0;
   int          bad = 0;
   always #5 clk_i = ~clk_i;
   wb_rr_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i), .timeout_o(timeout_o)
   );
   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask
   task automatic do_reset;
      rst_n_i = 1'b0;
      {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
      m0_sel_i = 4'hF; m1_sel_i = 4'hF;
      m0_adr_i = A0; m1_adr_i = A1;
      m0_dat_i = '0; m1_dat_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2 rst_n_i = 1'b1;
   endtask
   task automatic test_reset;
      do_reset();
      tick();
      total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc_o); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
      total++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin bad++; $display("FAIL reset_resp got=%b exp=0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
   endtask
   task automatic test_single_read;
      do_reset();
      tick();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0010;
      #1;
      total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL rd_latency_pre got=%b exp=0", s_cyc_o); end
      tick();
      total++; if (s_cyc_o !== 1'b1) begin bad++; $display("FAIL rd_latency_post got=%b exp=1", s_cyc_o); end
      total++; if (s_adr_o !== 32'h10) begin bad++; $display("FAIL rd_adr got=%h exp=00000010", s_adr_o); end
      tick();
      tick();
      s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
      #1;
      total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin bad++; $display("FAIL rd_ack got=%b exp=10", {m0_ack_o, m1_ack_o}); end
      total++; if (m0_dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", m0_dat_o); end
      tick();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      tick();
   endtask
   task automatic test_tie;
      do_reset();
      tick();
      m0_cyc_i = 1; m1_cyc_i = 1;
      tick();
      total++; if (s_adr_o !== A0) begin bad++; $display("FAIL tie_first got=%h exp=%h", s_adr_o, A0); end
      m0_cyc_i = 0;
      tick();
      total++; if ({s_cyc_o, s_adr_o} !== {1'b1, A1}) begin bad++; $display("FAIL tie_handover got=%b/%h exp=1/%h", s_cyc_o, s_adr_o, A1); end
      m1_cyc_i = 0;
      tick();
      m0_cyc_i = 1; m1_cyc_i = 1;
      tick();
      total++; if ({s_cyc_o, s_adr_o} !== {1'b1, A0}) begin bad++; $display("FAIL tie_second got=%b/%h exp=1/%h", s_cyc_o, s_adr_o, A0); end
      m0_cyc_i = 0; m1_cyc_i = 0;
      tick();
   endtask
   task automatic test_back_to_back;
      do_reset();
      tick();
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'b0011; m1_dat_i = 32'h1234;
      m1_adr_i = 32'h20;
      tick();
      m0_cyc_i = 1; m0_stb_i = 1;
      for (int i = 0; i < 4; i++) begin
         m1_adr_i = 32'h20 + 32'(4 * i);
         s_ack_i = 1;
         #1;
         total++; if ({m1_ack_o, m0_ack_o} !== 2'b10) begin bad++; $display("FAIL b2b_ack%0d got=%b exp=10", i, {m1_ack_o, m0_ack_o}); end
         total++; if ({s_we_o, s_sel_o, s_dat_o, s_adr_o} !== {1'b1, 4'b0011, 32'h1234, 32'h20 + 32'(4 * i)}) begin bad++; $display("FAIL b2b_req%0d got=%b/%b/%h/%h", i, s_we_o, s_sel_o, s_dat_o, s_adr_o); end
         tick();
      end
      s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
      #1;
      total++; if (m0_ack_o !== 1'b0) begin bad++; $display("FAIL b2b_m0_wait got=%b exp=0", m0_ack_o); end
      tick();
      total++; if ({s_cyc_o, s_adr_o} !== {1'b1, A0}) begin bad++; $display("FAIL b2b_m0_grant got=%b/%h exp=1/%h", s_cyc_o, s_adr_o, A0); end
      m0_cyc_i = 0; m0_stb_i = 0;
      tick();
   endtask
   task automatic test_timeout;
      do_reset();
      tick();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
      tick();
      for (int i = 0; i < 8; i++) begin
         total++; if ({s_cyc_o, m0_err_o, timeout_o} !== 3'b100) begin bad++; $display("FAIL to_stall%0d got=%b exp=100", i, {s_cyc_o, m0_err_o, timeout_o}); end
         tick();
      end
      s_ack_i = 1;
      #1;
      total++; if ({m0_err_o, timeout_o, m1_err_o} !== 3'b110) begin bad++; $display("FAIL to_pulse got=%b exp=110", {m0_err_o, timeout_o, m1_err_o}); end
      total++; if ({s_cyc_o, s_stb_o, m0_ack_o} !== 3'b000) begin bad++; $display("FAIL to_abort got=%b exp=000", {s_cyc_o, s_stb_o, m0_ack_o}); end
      tick();
      total++; if ({m0_err_o, timeout_o, m0_ack_o, s_cyc_o} !== 4'b0000) begin bad++; $display("FAIL to_one_shot got=%b exp=0000", {m0_err_o, timeout_o, m0_ack_o, s_cyc_o}); end
      m0_cyc_i = 0; m0_stb_i = 0;
      tick();
      s_ack_i = 0;
      tick();
   endtask
   task automatic test_ack_at_limit;
      do_reset();
      tick();
      m0_cyc_i = 1; m0_stb_i = 1;
      tick();
      repeat (7) tick();
      s_ack_i = 1;
      #1;
      total++; if ({m0_ack_o, m0_err_o} !== 2'b10) begin bad++; $display("FAIL lim_ack got=%b exp=10", {m0_ack_o, m0_err_o}); end
      tick();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      #1;
      total++; if ({timeout_o, m0_err_o} !== 2'b00) begin bad++; $display("FAIL lim_no_err got=%b exp=00", {timeout_o, m0_err_o}); end
      tick();
   endtask
   task automatic test_reset_mid;
      do_reset();
      tick();
      m1_cyc_i = 1; m1_stb_i = 1;
      tick();
      s_ack_i = 1; m0_cyc_i = 1;
      #1;
      total++; if (m1_ack_o !== 1'b1) begin bad++; $display("FAIL rstm_pre got=%b exp=1", m1_ack_o); end
      rst_n_i = 0;
      #1;
      total++; if ({s_cyc_o, s_stb_o, m1_ack_o, s_adr_o} !== {3'b000, 32'h0}) begin bad++; $display("FAIL rstm_async got=%b%b%b/%h exp=000/0", s_cyc_o, s_stb_o, m1_ack_o, s_adr_o); end
      s_ack_i = 0;
      tick();
      rst_n_i = 1;
      #1;
      total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL rstm_idle got=%b exp=0", s_cyc_o); end
      tick();
      total++; if ({s_cyc_o, s_adr_o} !== {1'b1, A0}) begin bad++; $display("FAIL rstm_m0_first got=%b/%h exp=1/%h", s_cyc_o, s_adr_o, A0); end
      m0_cyc_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      tick();
   endtask
   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_back_to_back();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
